tube_readout: RTL and testbench
===============================

// Module: tube_readout
// PURPOSE
//  Readout controller for the drift-tube timing channels. On a trigger it releases and
//  gates all tube channels for a fixed window. It then snapshots their 8-bit
//  clock-cycle counts and re-clears the channels. Finally it streams one framed event
//  (header, event number, one byte per tube) over a valid/ready byte interface
//  toward the host link.
// PARAMETERS
//  NUM_TUBES   16     number of tube channels read per event (1..64)
//  CNT_W       8      width of each tube count (fixed 8 in this design; checked)
//  WINDOW_CYC  256    cycles gate_enable stays high per event (2..65535)
//  HEADER      8'hA5  first byte of every frame
// PORTS
//  clk          in   1               system clock
//  clr_n        in   1               asynchronous active-low reset
//  trigger      in   1               event trigger, sampled on clk, level >=1 cycle
//  tube_data    in   NUM_TUBES*8     channel counts, tube i at [8*i+7:8*i]
//  tube_clr     out  1               clear to all tube channels, active-high
//  gate_enable  out  1               latch gate enable to all tube channels
//  out_data     out  8               frame byte
//  out_valid    out  1               out_data valid
//  out_ready    in   1               sink accepts byte when out_valid & out_ready
//  busy         out  1               high in any state other than IDLE
//  trig_dropped out  1               1-cycle pulse: trigger seen while busy
//  evt_num      out  8               number of the next event to be sent
// BEHAVIOUR
//  Reset (async, clr_n=0):
//   - state IDLE; tube_clr=1, gate_enable=0, out_valid=0, out_data=0.
//   - busy=0, trig_dropped=0, evt_num=0. Snapshot registers are 0.
//  IDLE:
//   - tube_clr=1, gate_enable=0.
//   - trigger=1 at edge T moves to WINDOW: from T+1 tube_clr=0, gate_enable=1,
//     window counter=0.
//  WINDOW:
//   - Window counter increments each cycle.
//   - On the cycle with counter==WINDOW_CYC-1, all tube_data is registered into the
//     snapshot and the state moves to SEND.
//   - gate_enable is high for exactly WINDOW_CYC cycles.
//  SEND:
//   - tube_clr=1, gate_enable=0 from the first SEND cycle.
//   - Byte order: HEADER, evt_num, snap[0] .. snap[NUM_TUBES-1], giving NUM_TUBES+2
//     bytes in total.
//   - out_valid rises on the first SEND cycle.
//  Handshake:
//   - A byte transfers when out_valid & out_ready on a clk edge.
//   - While out_valid & !out_ready, out_data and out_valid hold stable.
//   - After a transfer, the next byte is presented in the following cycle with no
//     bubble, so there is 1 byte/cycle with out_ready held high.
//  End of frame:
//   - On acceptance of the last byte: out_valid=0, evt_num increments mod 256
//     (255->0), and the state returns to IDLE.
//  Triggers while busy:
//   - Any trigger=1 while busy=1 is ignored and pulses trig_dropped for that cycle.
//     This includes the cycle the last byte is accepted.
//   - A trigger held high continuously re-arms only after one IDLE cycle.
//  Counts:
//   - Tube counts are passed through unmodified. A saturated 255 means no hit in
//     the window.
//   - The snapshot is taken before tube_clr reasserts, so later channel clears never
//     corrupt the frame.
//  Reset mid-operation:
//   - Aborts immediately to the reset values above. A partial frame is abandoned;
//     the sink sees out_valid drop.
// STRUCTURE
//  Shared package tube_pkg:
//   - state encoding IDLE/WINDOW/SEND
//   - HEADER constant
//   - TUBE_CNT_W=8
//   - frame length function NUM_TUBES+2
//  Sub-module tube_frame_mux (combinational):
//   - Selects out_data from byte index: 0 gives HEADER, 1 gives evt_num,
//     k>=2 gives snap[k-2].
//  Top level holds the FSM, window counter, byte index counter, snapshot array and
//  evt_num.
// TESTING
//  T1 reset: clr_n=0 mid-SEND -> outputs at reset values the same cycle (async);
//     tube_clr=1, evt_num=0.
//  T2 basic event:
//   - NUM_TUBES=4, WINDOW_CYC=8, tube_data={8'd40,8'd255,8'd3,8'd0}, out_ready=1.
//   - Pulse trigger -> gate_enable high exactly 8 cycles.
//   - Stream is A5,00,00,03,FF,28 on 6 consecutive cycles, then evt_num=1.
//  T3 backpressure:
//   - Hold out_ready=0 for 5 cycles on byte 2 -> out_data stable at snap[0].
//   - No bytes lost or duplicated; frame identical to T2.
//  T4 dropped trigger:
//   - Trigger pulses during WINDOW and during the last SEND byte -> trig_dropped
//     pulses each time; only one frame is emitted.
//  T5 wrap:
//   - Run 257 events -> evt_num byte in frames 256 and 257 reads FF then 00.
//  T6 snapshot isolation:
//   - Change tube_data during SEND -> frame carries values captured at window end.

Source files
------------

// File: rtl/tube_pkg.sv
// Shared definitions for the drift-tube readout: FSM state encoding, frame
// constants and the frame-length helper used by the top level.
package tube_pkg;

    localparam int         TUBE_CNT_W  = 8;
    localparam logic [7:0] TUBE_HEADER = 8'hA5;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WINDOW = 2'd1,
        ST_SEND   = 2'd2
    } tube_state_e;

    // A frame is the header byte, the event number, then one byte per tube.
    function automatic int frame_len(input int num_tubes);
        return num_tubes + 2;
    endfunction

endpackage

// File: rtl/tube_frame_mux.sv
// Combinational byte selector for the outgoing frame: header, event number,
// then the snapshot count of each tube in ascending tube order.
module tube_frame_mux
    import tube_pkg::*;
#(
    parameter int         NUM_TUBES = 16,
    parameter logic [7:0] HEADER    = TUBE_HEADER,
    parameter int         IDX_W     = 5
) (
    input  logic [IDX_W-1:0]                idx_i,
    input  logic [7:0]                      evt_num_i,
    input  logic [NUM_TUBES*TUBE_CNT_W-1:0] snap_i,
    output logic [7:0]                      byte_o
);

    always_comb begin
        // NOTE: byte_o gets a default before any branch so every path assigns it and no latch is inferred.
        byte_o = 8'h00;
        if (idx_i == '0) begin
            byte_o = HEADER;
        end else if (idx_i == IDX_W'(1)) begin
            byte_o = evt_num_i;
        end else begin
            for (int k = 0; k < NUM_TUBES; k++) begin
                if (int'(idx_i) == k + 2) begin
                    byte_o = snap_i[k*TUBE_CNT_W +: TUBE_CNT_W];
                end
            end
        end
    end

endmodule

// File: rtl/tube_readout.sv
// Drift-tube readout controller: gates the tube channels for a fixed window on
// a trigger, snapshots their counts, and streams one framed event over valid/ready.
module tube_readout
    import tube_pkg::*;
#(
    parameter int         NUM_TUBES  = 16,
    parameter int         CNT_W      = TUBE_CNT_W,
    parameter int         WINDOW_CYC = 256,
    parameter logic [7:0] HEADER     = TUBE_HEADER
) (
    input  logic                       clk,
    input  logic                       clr_n,
    input  logic                       trigger,
    input  logic [NUM_TUBES*CNT_W-1:0] tube_data,
    output logic                       tube_clr,
    output logic                       gate_enable,
    output logic [7:0]                 out_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       busy,
    output logic                       trig_dropped,
    output logic [7:0]                 evt_num
);

    localparam int FRAME_LEN = frame_len(NUM_TUBES);
    localparam int IDX_W     = $clog2(FRAME_LEN);
    localparam int WIN_W     = (WINDOW_CYC > 1) ? $clog2(WINDOW_CYC) : 1;

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(FRAME_LEN - 1);
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW_CYC - 1);

    if (CNT_W != TUBE_CNT_W) begin : g_bad_cnt_w
        $error("tube_readout: CNT_W must be %0d", TUBE_CNT_W);
    end
    if (NUM_TUBES < 1 || NUM_TUBES > 64) begin : g_bad_num_tubes
        $error("tube_readout: NUM_TUBES must be in 1..64");
    end
    if (WINDOW_CYC < 2 || WINDOW_CYC > 65535) begin : g_bad_window
        $error("tube_readout: WINDOW_CYC must be in 2..65535");
    end

    tube_state_e                state_q, state_d;
    logic [WIN_W-1:0]           win_q,   win_d;
    logic [IDX_W-1:0]           idx_q,   idx_d;
    logic [7:0]                 evt_q,   evt_d;
    logic [NUM_TUBES*CNT_W-1:0] snap_q,  snap_d;
    logic [7:0]                 frame_byte;

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q <= ST_IDLE;
            win_q   <= '0;
            idx_q   <= '0;
            evt_q   <= '0;
        end else begin
            // NOTE: non-blocking assignments so all registers update from the same pre-edge values.
            state_q <= state_d;
            win_q   <= win_d;
            idx_q   <= idx_d;
            evt_q   <= evt_d;
        end
    end

    // NOTE: the snapshot array is reset too, because a cleared snapshot is part of the defined reset state.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            snap_q <= '0;
        end else begin
            snap_q <= snap_d;
        end
    end

    always_comb begin
        state_d = state_q;
        win_d   = win_q;
        idx_d   = idx_q;
        evt_d   = evt_q;
        snap_d  = snap_q;

        unique case (state_q)
            ST_IDLE: begin
                if (trigger) begin
                    state_d = ST_WINDOW;
                    win_d   = '0;
                end
            end

            ST_WINDOW: begin
                win_d = win_q + WIN_W'(1);
                // Capture while the gate is still open, before tube_clr reasserts.
                if (win_q == WIN_LAST) begin
                    snap_d  = tube_data;
                    idx_d   = '0;
                    state_d = ST_SEND;
                end
            end

            ST_SEND: begin
                if (out_ready) begin
                    if (idx_q == IDX_LAST) begin
                        evt_d   = evt_q + 8'd1;
                        state_d = ST_IDLE;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    tube_frame_mux #(
        .NUM_TUBES (NUM_TUBES),
        .HEADER    (HEADER),
        .IDX_W     (IDX_W)
    ) u_frame_mux (
        .idx_i     (idx_q),
        .evt_num_i (evt_q),
        .snap_i    (snap_q),
        .byte_o    (frame_byte)
    );

    assign gate_enable  = (state_q == ST_WINDOW);
    assign tube_clr     = (state_q != ST_WINDOW);
    assign out_valid    = (state_q == ST_SEND);
    assign busy         = (state_q != ST_IDLE);
    assign out_data     = out_valid ? frame_byte : 8'h00;
    assign trig_dropped = trigger & busy;
    assign evt_num      = evt_q;

endmodule

// File: tb/tb_tube_readout.sv
// Self-checking bench for tube_readout: frames are predicted from the tube data
// and an event counter kept by the bench, then compared with what the sink accepts.
module tb_tube_readout;

    localparam int NT   = 4;
    localparam int WIN  = 8;
    localparam int FLEN = NT + 2;

    typedef logic [7:0] byte_q_t [$];

    logic            clk = 1'b0;
    logic            clr_n;
    logic            trigger;
    logic [NT*8-1:0] tube_data;
    logic            tube_clr;
    logic            gate_enable;
    logic [7:0]      out_data;
    logic            out_valid;
    logic            out_ready;
    logic            busy;
    logic            trig_dropped;
    logic [7:0]      evt_num;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_evt  = 0;

    always #5 clk = ~clk;

    tube_readout #(
        .NUM_TUBES  (NT),
        .CNT_W      (8),
        .WINDOW_CYC (WIN),
        .HEADER     (8'hA5)
    ) dut (
        .clk          (clk),
        .clr_n        (clr_n),
        .trigger      (trigger),
        .tube_data    (tube_data),
        .tube_clr     (tube_clr),
        .gate_enable  (gate_enable),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .busy         (busy),
        .trig_dropped (trig_dropped),
        .evt_num      (evt_num)
    );

    // Reference frame: header, event number, then tube 0 .. tube NT-1 unmodified.
    function automatic byte_q_t model_frame(input logic [NT*8-1:0] d, input int evt);
        byte_q_t q;
        q.push_back(8'hA5);
        q.push_back(8'(evt % 256));
        for (int k = 0; k < NT; k++) q.push_back(d[8*k +: 8]);
        return q;
    endfunction

    // Returns -1 when equal, -2 on a length difference, else the first differing index.
    function automatic int first_diff(input byte_q_t got, input byte_q_t exp);
        if (got.size() != exp.size()) return -2;
        foreach (exp[i]) if (got[i] !== exp[i]) return i;
        return -1;
    endfunction

    function automatic logic [NT*8-1:0] rand_data();
        logic [NT*8-1:0] d;
        for (int k = 0; k < NT; k++) d[8*k +: 8] = 8'($urandom_range(0, 255));
        return d;
    endfunction

    // Runs one trigger-to-end-of-frame event, acting as the sink.
    // ready_mode: 0 always ready, 1 stall stall_len cycles on byte stall_at, 2 random.
    task automatic do_event(
        input  logic [NT*8-1:0] data,
        input  int              ready_mode,
        input  int              stall_at,
        input  int              stall_len,
        input  int              trig_win_at,
        input  bit              trig_last,
        input  bit              change_in_send,
        input  logic [NT*8-1:0] send_data,
        output byte_q_t         offered,
        output byte_q_t         accepted,
        output int              gate_cyc,
        output int              drops,
        output int              send_cyc,
        output int              clr_bad,
        output bit              timeout
    );
        int budget;
        int stall_left;
        bit rdy;
        offered    = {};
        accepted   = {};
        gate_cyc   = 0;
        drops      = 0;
        send_cyc   = 0;
        clr_bad    = 0;
        budget     = 0;
        stall_left = stall_len;
        @(negedge clk);
        tube_data = data;
        trigger   = 1'b1;
        out_ready = 1'b1;
        #1 if (trig_dropped) drops++;
        @(negedge clk);
        trigger = 1'b0;
        while (!out_valid && budget < 1000) begin
            if (gate_enable) gate_cyc++;
            if (tube_clr !== !gate_enable) clr_bad++;
            trigger = (trig_win_at >= 0) && (gate_cyc == trig_win_at + 1);
            #1 if (trig_dropped) drops++;
            @(negedge clk);
            budget++;
        end
        trigger = 1'b0;
        timeout = (budget >= 1000);
        while (!timeout && accepted.size() < FLEN) begin
            if (!out_valid || budget >= 5000) begin
                timeout = 1'b1;
            end else begin
                if (tube_clr !== 1'b1 || gate_enable !== 1'b0) clr_bad++;
                offered.push_back(out_data);
                if (change_in_send) tube_data = send_data;
                rdy = 1'b1;
                if (ready_mode == 1 && accepted.size() == stall_at && stall_left > 0) begin
                    rdy = 1'b0;
                    stall_left--;
                end else if (ready_mode == 2) begin
                    rdy = 1'($urandom_range(0, 1));
                end
                out_ready = rdy;
                trigger   = trig_last && rdy && (accepted.size() == FLEN - 1);
                #1 if (trig_dropped) drops++;
                if (rdy) accepted.push_back(offered[$]);
                send_cyc++;
                @(negedge clk);
                budget++;
            end
        end
        trigger   = 1'b0;
        out_ready = 1'b1;
    endtask

    task automatic test_reset;
        n_checks++;
        if (tube_clr !== 1'b1 || gate_enable !== 1'b0 || out_valid !== 1'b0 || out_data !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_outputs: clr=%b gate=%b valid=%b data=%h, required 1 0 0 00",
                     tube_clr, gate_enable, out_valid, out_data);
        end
        n_checks++;
        if (busy !== 1'b0 || trig_dropped !== 1'b0 || evt_num !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_status: busy=%b drop=%b evt=%h, required 0 0 00", busy, trig_dropped, evt_num);
        end
        trigger = 1'b1;
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || trig_dropped !== 1'b0 || gate_enable !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_trigger_ignored: busy=%b drop=%b gate=%b, required 0 0 0",
                     busy, trig_dropped, gate_enable);
        end
        trigger = 1'b0;
        clr_n   = 1'b1;
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || tube_clr !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release_idle: busy=%b clr=%b valid=%b, required 0 1 0", busy, tube_clr, out_valid);
        end
    endtask

    task automatic test_basic;
        logic [NT*8-1:0] d;
        byte_q_t off, acc, exp;
        int g, dr, sc, cb, fd;
        bit to;
        d = {8'd40, 8'd255, 8'd3, 8'd0};
        do_event(d, 0, 0, 0, -1, 1'b0, 1'b0, '0, off, acc, g, dr, sc, cb, to);
        exp = model_frame(d, exp_evt);
        exp_evt = (exp_evt + 1) % 256;
        n_checks++;
        if (to) begin n_fail++; $display("FAIL basic_timeout: event did not complete, required completion"); end
        n_checks++;
        if (g !== WIN) begin n_fail++; $display("FAIL basic_gate_cycles: got %0d required %0d", g, WIN); end
        fd = first_diff(acc, exp);
        n_checks++;
        if (fd != -1) begin n_fail++; $display("FAIL basic_frame: got %p required %p", acc, exp); end
        n_checks++;
        if (sc !== FLEN) begin n_fail++; $display("FAIL basic_consecutive: %0d send cycles, required %0d", sc, FLEN); end
        n_checks++;
        if (cb !== 0 || dr !== 0) begin
            n_fail++;
            $display("FAIL basic_clr_drop: %0d clr errors %0d drops, required 0 0", cb, dr);
        end
        n_checks++;
        if (evt_num !== 8'(exp_evt) || out_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_end: evt=%h valid=%b busy=%b, required %h 0 0", evt_num, out_valid, busy, 8'(exp_evt));
        end
    endtask

    task automatic test_backpressure;
        logic [NT*8-1:0] d;
        byte_q_t off, acc, exp;
        int g, dr, sc, cb, fd, unstable;
        bit to;
        for (int pass = 0; pass < 2; pass++) begin
            d = (pass == 0) ? {8'd40, 8'd255, 8'd3, 8'd0} : rand_data();
            if (pass == 1) d[7:0] = d[7:0] | 8'h01;
            do_event(d, 1, 2, 5, -1, 1'b0, 1'b0, '0, off, acc, g, dr, sc, cb, to);
            exp = model_frame(d, exp_evt);
            exp_evt = (exp_evt + 1) % 256;
            n_checks++;
            if (to) begin n_fail++; $display("FAIL bp_timeout: pass %0d did not complete", pass); end
            fd = first_diff(acc, exp);
            n_checks++;
            if (fd != -1) begin n_fail++; $display("FAIL bp_frame: pass %0d got %p required %p", pass, acc, exp); end
            n_checks++;
            if (sc !== FLEN + 5) begin n_fail++; $display("FAIL bp_cycles: got %0d required %0d", sc, FLEN + 5); end
            unstable = 0;
            for (int i = 2; i < 8 && i < off.size(); i++) if (off[i] !== exp[2]) unstable++;
            n_checks++;
            if (unstable != 0 || off.size() < 8) begin
                n_fail++;
                $display("FAIL bp_hold: %0d unstable of %0d offered, required 0 unstable holding %h",
                         unstable, off.size(), exp[2]);
            end
        end
    endtask

    task automatic test_dropped_trigger;
        logic [NT*8-1:0] d;
        byte_q_t off, acc, exp;
        int g, dr, sc, cb, fd, extra;
        bit to;
        d = rand_data();
        do_event(d, 0, 0, 0, 3, 1'b1, 1'b0, '0, off, acc, g, dr, sc, cb, to);
        exp = model_frame(d, exp_evt);
        exp_evt = (exp_evt + 1) % 256;
        n_checks++;
        if (to || dr !== 2) begin n_fail++; $display("FAIL drop_pulses: got %0d (timeout %0b) required 2", dr, to); end
        fd = first_diff(acc, exp);
        n_checks++;
        if (fd != -1) begin n_fail++; $display("FAIL drop_frame: got %p required %p", acc, exp); end
        extra = 0;
        for (int i = 0; i < 12; i++) begin
            if (busy || out_valid) extra++;
            @(negedge clk);
        end
        n_checks++;
        if (extra != 0 || evt_num !== 8'(exp_evt)) begin
            n_fail++;
            $display("FAIL drop_single_frame: %0d busy cycles evt=%h, required 0 and %h", extra, evt_num, 8'(exp_evt));
        end
    endtask

    task automatic test_back_to_back;
        int busy_cyc;
        int drop_cyc;
        int budget;
        busy_cyc = 0;
        drop_cyc = 0;
        budget   = 0;
        @(negedge clk);
        out_ready = 1'b1;
        tube_data = rand_data();
        trigger   = 1'b1;
        @(negedge clk);
        while (busy && budget < 1000) begin
            busy_cyc++;
            if (trig_dropped) drop_cyc++;
            @(negedge clk);
            budget++;
        end
        n_checks++;
        if (busy_cyc !== WIN + FLEN || drop_cyc !== WIN + FLEN) begin
            n_fail++;
            $display("FAIL b2b_busy_drop: busy %0d drops %0d, required %0d each", busy_cyc, drop_cyc, WIN + FLEN);
        end
        n_checks++;
        if (busy !== 1'b0 || trig_dropped !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_idle_gap: busy=%b drop=%b, required 0 0", busy, trig_dropped);
        end
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b1 || gate_enable !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_rearm: busy=%b gate=%b, required 1 1", busy, gate_enable);
        end
        trigger = 1'b0;
        budget  = 0;
        while (busy && budget < 1000) begin
            @(negedge clk);
            budget++;
        end
        exp_evt = (exp_evt + 2) % 256;
        n_checks++;
        if (busy !== 1'b0 || evt_num !== 8'(exp_evt)) begin
            n_fail++;
            $display("FAIL b2b_evt: busy=%b evt=%h, required 0 %h", busy, evt_num, 8'(exp_evt));
        end
    endtask

    task automatic test_snapshot;
        logic [NT*8-1:0] d;
        byte_q_t off, acc, exp;
        int g, dr, sc, cb, fd;
        bit to;
        d = rand_data();
        do_event(d, 2, 0, 0, -1, 1'b0, 1'b1, ~d, off, acc, g, dr, sc, cb, to);
        exp = model_frame(d, exp_evt);
        exp_evt = (exp_evt + 1) % 256;
        fd = first_diff(acc, exp);
        n_checks++;
        if (to || fd != -1) begin n_fail++; $display("FAIL snapshot_frame: got %p required %p", acc, exp); end
    endtask

    task automatic test_random_ready;
        logic [NT*8-1:0] d;
        byte_q_t off, acc, exp;
        int g, dr, sc, cb, fd;
        bit to;
        for (int n = 0; n < 6; n++) begin
            d = rand_data();
            do_event(d, 2, 0, 0, -1, 1'b0, 1'b0, '0, off, acc, g, dr, sc, cb, to);
            exp = model_frame(d, exp_evt);
            exp_evt = (exp_evt + 1) % 256;
            fd = first_diff(acc, exp);
            n_checks++;
            if (to || fd != -1 || g !== WIN) begin
                n_fail++;
                $display("FAIL random_frame%0d: got %p gate %0d, required %p gate %0d", n, acc, g, exp, WIN);
            end
        end
        n_checks++;
        if (evt_num !== 8'(exp_evt)) begin
            n_fail++;
            $display("FAIL random_evt: got %h required %h", evt_num, 8'(exp_evt));
        end
    endtask

    task automatic test_reset_mid_send;
        int budget;
        budget = 0;
        @(negedge clk);
        tube_data = rand_data();
        out_ready = 1'b1;
        trigger   = 1'b1;
        @(negedge clk);
        trigger = 1'b0;
        while (!out_valid && budget < 1000) begin
            @(negedge clk);
            budget++;
        end
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b1 || evt_num === 8'h00) begin
            n_fail++;
            $display("FAIL midsend_precondition: valid=%b evt=%h, required 1 and nonzero", out_valid, evt_num);
        end
        #2 clr_n = 1'b0;
        #1;
        n_checks++;
        if (tube_clr !== 1'b1 || gate_enable !== 1'b0 || out_valid !== 1'b0 || out_data !== 8'h00) begin
            n_fail++;
            $display("FAIL midsend_reset_outputs: clr=%b gate=%b valid=%b data=%h, required 1 0 0 00",
                     tube_clr, gate_enable, out_valid, out_data);
        end
        n_checks++;
        if (busy !== 1'b0 || evt_num !== 8'h00) begin
            n_fail++;
            $display("FAIL midsend_reset_status: busy=%b evt=%h, required 0 00", busy, evt_num);
        end
        @(negedge clk);
        clr_n   = 1'b1;
        exp_evt = 0;
    endtask

    task automatic test_wrap;
        logic [NT*8-1:0] d;
        byte_q_t off, acc, exp;
        int g, dr, sc, cb, fd;
        bit to;
        for (int n = 1; n <= 257; n++) begin
            d = rand_data();
            do_event(d, 0, 0, 0, -1, 1'b0, 1'b0, '0, off, acc, g, dr, sc, cb, to);
            exp = model_frame(d, exp_evt);
            exp_evt = (exp_evt + 1) % 256;
            fd = first_diff(acc, exp);
            n_checks++;
            if (to || fd != -1) begin n_fail++; $display("FAIL wrap_frame%0d: got %p required %p", n, acc, exp); end
            if (n == 256 || n == 257) begin
                n_checks++;
                if (acc.size() < 2 || acc[1] !== ((n == 256) ? 8'hFF : 8'h00)) begin
                    n_fail++;
                    $display("FAIL wrap_evt_byte%0d: got %p required evt byte %h", n, acc, (n == 256) ? 8'hFF : 8'h00);
                end
            end
        end
        n_checks++;
        if (evt_num !== 8'h01) begin n_fail++; $display("FAIL wrap_evt_num: got %h required 01", evt_num); end
    endtask

    initial begin
        clr_n     = 1'b0;
        trigger   = 1'b0;
        out_ready = 1'b1;
        tube_data = '0;
        repeat (2) @(negedge clk);
        test_reset;
        test_basic;
        test_backpressure;
        test_dropped_trigger;
        test_back_to_back;
        test_snapshot;
        test_random_ready;
        test_reset_mid_send;
        test_wrap;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
